clk_period_meter: RTL and testbench
===================================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 1000, clk_in cycles without a rising edge before stall is declared; SHALL satisfy 2 <= TIMEOUT <= 2**CNT_W-1 (elaboration-time check).
REQ-003 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  measurement enable.
REQ-006 sig_in  input  1  measured slow clock or divided clock, asynchronous to clk_in.
REQ-007 period_out  output  CNT_W  clk_in cycles between the last two rising edges of sig_in.
REQ-008 high_out  output  CNT_W  clk_in cycles sig_in was high within that period.
REQ-009 valid  output  1  one-cycle pulse; period_out/high_out updated this cycle.
REQ-010 stalled  output  1  no sig_in rising edge for TIMEOUT cycles.

Function
REQ-011 sig_s = conditioned sig_in (see Configuration); sig_d = sig_s registered; rise = sig_s & ~sig_d.
REQ-012 States: IDLE, MEASURE. Reset state IDLE.
REQ-013 IDLE: cnt and hcnt held at 0; on rise with en=1 -> MEASURE, cnt<=1, hcnt<=1, no valid.
REQ-014 MEASURE, rise: period_out<=cnt, high_out<=hcnt, valid<=1 next cycle, cnt<=1, hcnt<=1, stay MEASURE.
REQ-015 MEASURE, no rise: cnt<=cnt+1; hcnt<=hcnt+1 when sig_s=1, else hold.
REQ-016 MEASURE, no rise and cnt==TIMEOUT: -> IDLE, stalled<=1, no valid, period_out/high_out hold.
REQ-017 stalled clears on the next rise (entering MEASURE); it does not clear on timeout expiry itself.
REQ-018 en=0: state -> IDLE next cycle, counters cleared, period_out/high_out/stalled hold, valid=0; en has priority over rise and timeout.
REQ-019 valid is never asserted on two consecutive cycles (minimum detectable period is 2 cycles).
REQ-020 Outputs registered; no combinational input-to-output path.
REQ-021 Example: sig_in high 2 / low 2 cycles -> period_out=4, high_out=2.

Reset
REQ-022 rst=1 at a clk_in edge: state IDLE, cnt=hcnt=0, period_out=0, high_out=0, valid=0, stalled=0, sync/edge registers 0.
REQ-023 rst has priority over en, rise and timeout; reset mid-measurement discards the partial count, and the first post-reset rise produces no valid.

Configuration
REQ-024 Macro CLK_PERIOD_METER_SYNC_EN defined: sig_s is sig_in through a two-flop synchronizer; valid rises 4 clk_in edges after the edge that first samples sig_in high.
REQ-025 Macro undefined: sig_s = sig_in directly (caller guarantees synchronous input); latency 2 edges; measured values are identical in both builds.

Structure
REQ-026 Package clk_meter_pkg SHALL hold the state enum (IDLE, MEASURE) and the CNT_W default constant.
REQ-027 One sub-module, edge_detect (optional synchronizer under the macro, sig_d register, rise output); counters and FSM stay in clk_period_meter.

Verification
REQ-028 sig_in 2 high/2 low, en=1, 5 periods -> first rise no valid; 4 valid pulses spaced 4 cycles, period_out=4, high_out=2.
REQ-029 sig_in 2 high/1 low -> period_out=3, high_out=2; 1 high/1 low -> period_out=2, high_out=1, valid every other cycle.
REQ-030 TIMEOUT=20, sig_in stops low after 3 periods -> stalled=1 exactly 20 cycles after last rise, no valid; resume -> stalled clears at first rise, valid at second.
REQ-031 rst pulsed mid-period -> all outputs 0 next cycle; next valid only after two post-reset rises.
REQ-032 en dropped for 10 cycles mid-period -> no valid, outputs hold; after en=1 first rise re-arms, second rise gives correct period.
REQ-033 Both builds (macro defined/undefined) run REQ-028 -> identical values; valid offset by exactly 2 cycles.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// ---------------------------------------------------------------------------
// clk_meter_pkg
//   Shared definitions for the clock period meter:
//     - CNT_W_DEFAULT : default width of the cycle counters and results
//     - meter_state_t : measurement FSM states (IDLE, MEASURE)
// ---------------------------------------------------------------------------
package clk_meter_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
//   Conditions the measured signal and flags its rising edges.
//   Build option CLK_PERIOD_METER_SYNC_EN:
//     defined   - sig_in passes through a two-flop synchronizer first
//     undefined - sig_in is used directly (caller guarantees it is
//                 synchronous to clk_in)
//   Ports:
//     clk_in  in   sampling clock, rising edge
//     rst     in   synchronous active-high reset
//     sig_in  in   measured signal
//     sig_s   out  conditioned signal
//     rise    out  sig_s high while its previous sample was low
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sig_s,
  output logic rise
);

`ifdef CLK_PERIOD_METER_SYNC_EN
  localparam int SYNC_STAGES = 2;

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign sig_s = sync_reg[SYNC_STAGES-1];
`else
  assign sig_s = sig_in;
`endif

  logic sig_d_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sig_d_reg <= 1'b0;
    end else begin
      sig_d_reg <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d_reg;

endmodule

// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
//   Measures the period and high time of sig_in in clk_in cycles.
//   Build option CLK_PERIOD_METER_SYNC_EN adds a two-flop synchronizer on
//   sig_in (two cycles more latency, identical measured values).
//   Parameters:
//     CNT_W    width of counters and results
//     TIMEOUT  cycles without a rising edge before stall (2..2**CNT_W-1)
//   Ports:
//     clk_in      in   clock, rising edge
//     rst         in   synchronous active-high reset
//     en          in   measurement enable
//     sig_in      in   measured signal
//     period_out  out  cycles between the last two rising edges
//     high_out    out  cycles sig_in was high within that period
//     valid       out  one-cycle pulse when period_out/high_out update
//     stalled     out  no rising edge seen for TIMEOUT cycles
// ---------------------------------------------------------------------------
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             stalled
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (TIMEOUT < 2 || longint'(TIMEOUT) > CNT_MAX) begin : g_bad_timeout
    $error("clk_period_meter: TIMEOUT must lie in 2 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic sig_s;
  logic rise;

  edge_detect u_edge_detect (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise)
  );

  meter_state_t     state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] hcnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_reg;
  logic             valid_reg;
  logic             stalled_reg;

  // Priority: rst, then en, then rise, then timeout. The counters start at 1
  // on a rise because the rising-edge cycle itself belongs to the new period
  // and is a high cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hcnt_reg    <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      stalled_reg <= 1'b0;
    end else if (!en) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hcnt_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (rise) begin
            // First edge only arms the measurement; there is no prior edge.
            state_reg   <= MEASURE;
            cnt_reg     <= CNT_ONE;
            hcnt_reg    <= CNT_ONE;
            stalled_reg <= 1'b0;
          end else begin
            cnt_reg  <= '0;
            hcnt_reg <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_reg <= cnt_reg;
            high_reg   <= hcnt_reg;
            valid_reg  <= 1'b1;
            cnt_reg    <= CNT_ONE;
            hcnt_reg   <= CNT_ONE;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            state_reg   <= IDLE;
            stalled_reg <= 1'b1;
            valid_reg   <= 1'b0;
            cnt_reg     <= '0;
            hcnt_reg    <= '0;
          end else begin
            valid_reg <= 1'b0;
            cnt_reg   <= cnt_reg + CNT_ONE;
            if (sig_s) begin
              hcnt_reg <= hcnt_reg + CNT_ONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          cnt_reg   <= '0;
          hcnt_reg  <= '0;
        end
      endcase
    end
  end

  assign period_out = period_reg;
  assign high_out   = high_reg;
  assign valid      = valid_reg;
  assign stalled    = stalled_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_period_meter
//   Drives clk_period_meter with directed and random waveforms and compares
//   every cycle against a timestamp-based reference model: a period is the
//   distance between two rising-edge times, the high time is the number of
//   high samples between them, and a stall is declared once the distance
//   from the last rising edge reaches TIMEOUT.
// ---------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int MAXC    = 4096;

`ifdef CLK_PERIOD_METER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             stalled;

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .stalled    (stalled)
  );

  always #5 clk_in = ~clk_in;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;
  int cyc        = 0;
  int valid_seen = 0;

  bit rst_h  [MAXC];
  bit sigin_h[MAXC];
  bit sigs_h [MAXC];

  // reference model state
  bit m_armed   = 1'b0;
  bit m_stalled = 1'b0;
  bit m_valid   = 1'b0;
  int m_last    = 0;
  int m_period  = 0;
  int m_high    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Signal the meter actually sees at edge n: the raw input, or the input
  // two edges earlier when the synchronizer is built in (its flops are
  // cleared by reset).
  function automatic bit cond_sig(input int n);
    if (SYNC_LAT == 0) return sigin_h[n];
    if (n < 2) return 1'b0;
    if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
    return sigin_h[n-2];
  endfunction

  task automatic step(input bit r, input bit e, input bit s);
    int n;
    bit prev;
    bit rise;
    int hsum;
    @(negedge clk_in);
    rst    = r;
    en     = e;
    sig_in = s;
    @(posedge clk_in);
    n = cyc;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", n, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    rst_h[n]   = r;
    sigin_h[n] = s;
    sigs_h[n]  = cond_sig(n);
    prev = (n == 0) ? 1'b0 : (rst_h[n-1] ? 1'b0 : sigs_h[n-1]);
    rise = sigs_h[n] & ~prev;

    m_valid = 1'b0;
    if (r) begin
      m_armed   = 1'b0;
      m_stalled = 1'b0;
      m_period  = 0;
      m_high    = 0;
    end else if (!e) begin
      m_armed = 1'b0;
    end else if (rise) begin
      if (m_armed) begin
        hsum = 0;
        for (int k = m_last; k < n; k++) hsum += int'(sigs_h[k]);
        m_period = n - m_last;
        m_high   = hsum;
        m_valid  = 1'b1;
      end else begin
        m_stalled = 1'b0;
      end
      m_armed = 1'b1;
      m_last  = n;
    end else if (m_armed && (n - m_last) >= TIMEOUT) begin
      m_armed   = 1'b0;
      m_stalled = 1'b1;
    end

    #1;
    check("valid",   valid,      m_valid);
    check("period",  period_out, m_period);
    check("high",    high_out,   m_high);
    check("stalled", stalled,    m_stalled);
    if (valid === 1'b1) valid_seen++;
    cyc++;
  endtask

  task automatic wave(input int h, input int l, input int np, input bit e);
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < h; i++) step(1'b0, e, 1'b1);
      for (int i = 0; i < l; i++) step(1'b0, e, 1'b0);
    end
  endtask

  task automatic idle_low(input int k, input bit e);
    for (int i = 0; i < k; i++) step(1'b0, e, 1'b0);
  endtask

  initial begin
    int h;
    int l;
    bit e;

    // reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("rst_period",  period_out, 0);
    check("rst_high",    high_out,   0);
    check("rst_valid",   valid,      0);
    check("rst_stalled", stalled,    0);
    idle_low(3, 1'b1);

    // 2 high / 2 low, five periods: four results of 4/2
    valid_seen = 0;
    wave(2, 2, 5, 1'b1);
    idle_low(4, 1'b1);
    check("ex22_count",  valid_seen, 4);
    check("ex22_period", period_out, 4);
    check("ex22_high",   high_out,   2);

    // 2 high / 1 low, then the minimum period 1 high / 1 low
    wave(2, 1, 4, 1'b1);
    check("ex21_period", period_out, 3);
    check("ex21_high",   high_out,   2);
    wave(1, 1, 6, 1'b1);
    check("ex11_period", period_out, 2);
    check("ex11_high",   high_out,   1);

    // stall after the signal stops low, then resume
    wave(2, 2, 3, 1'b1);
    idle_low(25, 1'b1);
    check("stall_set", stalled, 1);
    wave(2, 2, 3, 1'b1);
    check("stall_clear",  stalled,    0);
    check("resume_period", period_out, 4);

    // reset in the middle of a period
    wave(3, 2, 2, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_period", period_out, 0);
    check("midrst_valid",  valid,      0);
    wave(2, 2, 4, 1'b1);

    // enable dropped for 10 cycles mid-period
    wave(3, 3, 2, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i[1]);
    wave(3, 3, 3, 1'b1);
    check("en_period", period_out, 6);
    check("en_high",   high_out,   3);

    // random periods, occasional enable drops, resets and long gaps
    for (int t = 0; t < 60; t++) begin
      h = int'($urandom_range(1, 7));
      l = int'($urandom_range(1, 7));
      e = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) l = int'($urandom_range(15, 25));
      wave(h, l, 1, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
